// File: rtl/upsample_ub_pkg.sv
// upsample_ub_pkg: shared types and helpers for the nearest-neighbour
// up-sample unified buffer.
//   bank_state_t : occupancy state of one ping-pong bank
//   clog2_min1   : counter width for a 0..v-1 range, never below 1 bit
package upsample_ub_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ub_bank_ram.sv
// ub_bank_ram: simple dual-port RAM, one write port and one read port.
// The read data is registered and only updates when re is high, so it
// holds its value across downstream stalls. rst clears the read register
// only; the array itself is not reset.
// Ports:
//   clk          clock (posedge)
//   rst          synchronous active-high, clears rdata
//   we/waddr/wdata  synchronous write port
//   re/raddr     read enable / address
//   rdata        registered read data
module ub_bank_ram
  import upsample_ub_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/upsample_ub.sv
// upsample_ub: nearest-neighbour up-sample unified buffer.
// A raster-order IN_W x IN_H frame is written into one half of a two-bank
// RAM while the other half is read back scaled by SCALE_X x SCALE_Y.
// Ports:
//   clk, rst (sync, active-high), flush (control restart, RAM kept)
//   in_valid/in_ready/in_data       input pixel stream
//   out_valid/out_ready/out_data    output pixel stream
//   out_last                        final pixel of an output frame
// Optional (macro UPSAMPLE_UB_STATS_EN):
//   frames_out[15:0]   out_last handshakes, wrapping
//   stall_cycles[31:0] cycles with out_valid && !out_ready, saturating
module upsample_ub
  import upsample_ub_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int IN_W    = 64,
  parameter int IN_H    = 64,
  parameter int SCALE_X = 2,
  parameter int SCALE_Y = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef UPSAMPLE_UB_STATS_EN
  ,
  output logic [15:0]       frames_out,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int FRAME = IN_W * IN_H;
  localparam int DEPTH = 2 * FRAME;
  localparam int AW    = clog2_min1(DEPTH);
  localparam int XW    = clog2_min1(IN_W);
  localparam int YW    = clog2_min1(IN_H);
  localparam int RXW   = clog2_min1(SCALE_X);
  localparam int RYW   = clog2_min1(SCALE_Y);

  localparam logic [XW-1:0]  X_MAX  = XW'(IN_W - 1);
  localparam logic [YW-1:0]  Y_MAX  = YW'(IN_H - 1);
  localparam logic [RXW-1:0] RX_MAX = RXW'(SCALE_X - 1);
  localparam logic [RYW-1:0] RY_MAX = RYW'(SCALE_Y - 1);

  logic clr;
  assign clr = rst | flush;

  bank_state_t bank_st [2];
  logic        wr_bank, rd_bank;

  // ---------------- write side ----------------
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;
  logic          wr_fire, wr_end;
  logic [AW-1:0] waddr;

  assign in_ready = (bank_st[wr_bank] == BANK_EMPTY) && !clr;
  assign wr_fire  = in_valid && in_ready;
  assign wr_end   = (wx == X_MAX) && (wy == Y_MAX);
  assign waddr    = AW'((wr_bank ? FRAME : 0) + int'(wy) * IN_W + int'(wx));

  always_ff @(posedge clk) begin
    if (clr) begin
      wx      <= '0;
      wy      <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      if (wx == X_MAX) begin
        wx <= '0;
        if (wy == Y_MAX) begin
          wy      <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wy <= wy + 1'b1;
        end
      end else begin
        wx <= wx + 1'b1;
      end
    end
  end

  // ---------------- read side ----------------
  // sx/sy walk source pixels, rx/ry count replications, so the source
  // address needs no divide by the scale factors.
  logic [XW-1:0]  sx;
  logic [RXW-1:0] rx;
  logic [YW-1:0]  sy;
  logic [RYW-1:0] ry;
  logic           rd_done;     // every coordinate of this frame issued
  logic           rd_release;  // final pixel of the frame handed off
  logic           cur_bank;    // bank the next issue reads from
  logic           issue, last_coord;
  logic [AW-1:0]  raddr;

  assign rd_release = out_valid && out_ready && out_last;
  // On a release the next frame may start in the same cycle, from the
  // other bank. Bank state is registered, so a bank the writer completes
  // this cycle is not seen as FULL until the next one.
  assign cur_bank   = rd_release ? ~rd_bank : rd_bank;
  assign issue      = !clr && (bank_st[cur_bank] == BANK_FULL) &&
                      (!out_valid || out_ready) && (rd_release || !rd_done);
  assign last_coord = (sx == X_MAX) && (rx == RX_MAX) &&
                      (sy == Y_MAX) && (ry == RY_MAX);
  assign raddr      = AW'((cur_bank ? FRAME : 0) + int'(sy) * IN_W + int'(sx));

  always_ff @(posedge clk) begin
    if (clr) begin
      sx      <= '0;
      rx      <= '0;
      sy      <= '0;
      ry      <= '0;
      rd_done <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      rd_done <= (rd_release ? 1'b0 : rd_done) | (issue && last_coord);
      if (rd_release) rd_bank <= ~rd_bank;
      if (issue) begin
        if (rx == RX_MAX) begin
          rx <= '0;
          if (sx == X_MAX) begin
            sx <= '0;
            if (ry == RY_MAX) begin
              ry <= '0;
              sy <= (sy == Y_MAX) ? '0 : sy + 1'b1;
            end else begin
              ry <= ry + 1'b1;
            end
          end else begin
            sx <= sx + 1'b1;
          end
        end else begin
          rx <= rx + 1'b1;
        end
      end
    end
  end

  // Writer completion and reader release always target different banks.
  always_ff @(posedge clk) begin
    if (clr) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else begin
      if (wr_fire && wr_end) bank_st[wr_bank] <= BANK_FULL;
      if (rd_release)        bank_st[rd_bank] <= BANK_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_last  <= last_coord;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // out_data is the RAM read register; it only reloads on issue, which
  // never happens during a stall, and only rst (not flush) clears it.
  ub_bank_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_fire),
    .waddr(waddr),
    .wdata(in_data),
    .re   (issue),
    .raddr(raddr),
    .rdata(out_data)
  );

`ifdef UPSAMPLE_UB_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      frames_out   <= '0;
      stall_cycles <= '0;
    end else begin
      if (rd_release) frames_out <= frames_out + 16'd1;
      if (out_valid && !out_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_upsample_ub.sv
module tb_upsample_ub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [15:0] a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [15:0] b_in_data, b_out_data;
`ifdef UPSAMPLE_UB_STATS_EN
  logic [15:0] a_frames_out, b_frames_out;
  logic [31:0] a_stall_cycles, b_stall_cycles;
`endif

  upsample_ub #(.DATA_W(16), .IN_W(4), .IN_H(2), .SCALE_X(2), .SCALE_Y(2)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last)
`ifdef UPSAMPLE_UB_STATS_EN
    , .frames_out(a_frames_out), .stall_cycles(a_stall_cycles)
`endif
  );

  upsample_ub #(.DATA_W(16), .IN_W(3), .IN_H(1), .SCALE_X(3), .SCALE_Y(1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last)
`ifdef UPSAMPLE_UB_STATS_EN
    , .frames_out(b_frames_out), .stall_cycles(b_stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Source pixel index of each output of a 4x2 frame scaled 2x2.
  int exp_idx [32] = '{0,0,1,1,2,2,3,3, 0,0,1,1,2,2,3,3,
                       4,4,5,5,6,6,7,7, 4,4,5,5,6,6,7,7};

  int in_q  [$];
  int exp_d [$];
  bit exp_l [$];

  task automatic load_frame(input int base);
    for (int i = 0; i < 8; i++) in_q.push_back(base + i);
    for (int i = 0; i < 32; i++) begin
      exp_d.push_back(base + exp_idx[i]);
      exp_l.push_back(i == 31);
    end
  endtask

  // Cycle engine for dut_a: feeds in_q, checks handshaked outputs against
  // exp_d/exp_l. rdy_mode 0: always ready, 1: ready 1,0,1,0..., 2: drop
  // ready for the first stall_budget cycles that have out_valid.
  task automatic run_a(input int rdy_mode, input int stall_budget, input bit chk_rdy,
                       input bit chk_gap, input int max_cyc);
    int cyc = 0, n_fed = 0, n_last = 0, t_in = -1, first_v = -1;
    int stalls = stall_budget;
    bit prev_stall = 0;
    logic [15:0] pd;
    logic pl;
    while ((in_q.size() > 0 || exp_d.size() > 0) && cyc < max_cyc) begin
      @(negedge clk);
      case (rdy_mode)
        0: a_out_ready = 1'b1;
        1: a_out_ready = (cyc % 2 == 0);
        default: begin
          if (a_out_valid && stalls > 0) begin a_out_ready = 1'b0; stalls--; end
          else a_out_ready = 1'b1;
        end
      endcase
      a_in_valid = (in_q.size() > 0);
      if (in_q.size() > 0) a_in_data = 16'(in_q[0]);
      #1;
      if (chk_rdy) begin
        if (n_fed >= 8 && n_fed < 16)      chk("in_ready_frame2", a_in_ready, 1);
        else if (n_fed == 16 && n_last == 0) chk("in_ready_both_full", a_in_ready, 0);
        else if (n_fed == 16 && n_last == 1) chk("in_ready_after_release", a_in_ready, 1);
      end
      if (prev_stall) begin
        chk("stall_valid", a_out_valid, 1);
        chk("stall_data", a_out_data, pd);
        chk("stall_last", a_out_last, pl);
      end
      if (a_out_valid && first_v < 0) first_v = cyc;
      if (chk_gap && first_v >= 0 && exp_d.size() > 0) chk("gapless", a_out_valid, 1);
      if (a_out_valid && a_out_ready) begin
        if (exp_d.size() == 0) chk("extra_output", 1, 0);
        else begin
          chk("out_data", a_out_data, exp_d.pop_front());
          chk("out_last", a_out_last, exp_l.pop_front());
          if (a_out_last) n_last++;
        end
      end
      prev_stall = a_out_valid && !a_out_ready;
      pd = a_out_data;
      pl = a_out_last;
      if (a_in_valid && a_in_ready) begin
        void'(in_q.pop_front());
        n_fed++;
        if (n_fed == 8) t_in = cyc;
      end
      cyc++;
    end
    chk("pending_after_budget", in_q.size() + exp_d.size(), 0);
    chk("first_out_latency", first_v - t_in, 2);
    in_q.delete(); exp_d.delete(); exp_l.delete();
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
  endtask

  // Feed n partial-frame pixels to dut_a, one per cycle.
  task automatic feed_partial(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = 16'(base + i);
      #1 chk("partial_in_ready", a_in_ready, 1);
    end
  endtask

  typedef struct {
    int nframes;
    int b0, b1, b2;
    int rdy_mode;
  } vec_t;

  vec_t vecs [3];
  int   eb [9] = '{7,7,7,8,8,8,9,9,9};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{nframes: 1, b0: 0, b1: 0,  b2: 0,  rdy_mode: 0};
    vecs[1] = '{nframes: 1, b0: 0, b1: 0,  b2: 0,  rdy_mode: 1};
    vecs[2] = '{nframes: 3, b0: 0, b1: 10, b2: 20, rdy_mode: 0};

    rst = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_out_data", a_out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", a_in_ready, 1);

    // Table-driven frames on the 4x2, 2x2 instance.
    for (int v = 0; v < 3; v++) begin
      load_frame(vecs[v].b0);
      if (vecs[v].nframes == 3) begin
        load_frame(vecs[v].b1);
        load_frame(vecs[v].b2);
      end
      run_a(vecs[v].rdy_mode, 0, vecs[v].nframes == 3, vecs[v].rdy_mode == 0, 600);
    end

    // Reset mid-frame: partial frame must be discarded.
    feed_partial(100, 3);
    @(negedge clk);
    a_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", a_in_ready, 0);
    chk("midrst_out_valid", a_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", a_in_ready, 1);
    chk("after_rst_out_valid", a_out_valid, 0);
    chk("after_rst_out_last", a_out_last, 0);
    chk("after_rst_out_data", a_out_data, 0);
    load_frame(40);
    run_a(0, 0, 0, 1, 200);

    // Flush mid-frame: control restarts, out_data is left alone.
    feed_partial(200, 3);
    @(negedge clk);
    a_in_valid = 1'b0;
    flush = 1'b1;
    #1 chk("flush_in_ready", a_in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("after_flush_in_ready", a_in_ready, 1);
    chk("after_flush_out_valid", a_out_valid, 0);
    chk("after_flush_out_data_held", a_out_data, 47);
    load_frame(50);
    run_a(0, 0, 0, 1, 200);

    // 3x1 frame scaled 3x1 on the second instance.
    begin
      int k = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = 16'(7 + i);
        #1 chk("b_in_ready", b_in_ready, 1);
      end
      @(negedge clk);
      b_in_valid = 1'b0;
      for (int c = 0; c < 40 && k < 9; c++) begin
        #1;
        if (b_out_valid) begin
          chk("b_out_data", b_out_data, eb[k]);
          chk("b_out_last", b_out_last, k == 8);
          k++;
        end
        @(negedge clk);
      end
      chk("b_output_count", k, 9);
    end

`ifdef UPSAMPLE_UB_STATS_EN
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("stats_clear_frames", a_frames_out, 0);
    chk("stats_clear_stalls", a_stall_cycles, 0);
    load_frame(60);
    load_frame(70);
    run_a(2, 5, 0, 0, 400);
    @(negedge clk);
    #1;
    chk("stats_frames_out", a_frames_out, 2);
    chk("stats_stall_cycles", a_stall_cycles, 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("stats_flush_frames", a_frames_out, 0);
    chk("stats_flush_stalls", a_stall_cycles, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
